// File: rtl/laser_host.sv
// laser_host: loads a point pattern, resets and feeds the LASER engine,
// waits for its two circle centers, then scores how many points they cover.
module laser_host #(
  parameter int          NPTS    = 40,          // points per pattern (1..63)
  parameter logic [19:0] TMO_CYC = 20'd600000   // WAIT cycles before giving up
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_EN,
  input  logic [5:0] LD_ADDR,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  input  logic       START,
  output logic       DUT_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       BUSY,
  output logic       RES_VALID,
  output logic [5:0] SCORE,
  output logic [3:0] R1X,
  output logic [3:0] R1Y,
  output logic [3:0] R2X,
  output logic [3:0] R2Y,
  output logic       TIMEOUT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRST,
    ST_STREAM,
    ST_WAIT,
    ST_SCORE,
    ST_REPORT
  } state_t;

  localparam logic [5:0] LAST_IDX   = 6'(NPTS - 1);
  localparam logic [6:0] NPTS_LIMIT = 7'(NPTS);

  state_t      state_reg, state_next;
  logic [5:0]  idx_reg, idx_next;
  logic [19:0] wcnt_reg, wcnt_next;
  logic        done_take;
  logic        tmo_hit;

  // Point memory: {x,y} per entry, never reset so a pattern survives RST.
  logic [7:0]  mem [NPTS];
  logic        mem_we;
  logic [7:0]  pt_reg;
  logic [7:0]  xy_reg;

  logic        dut_rst_reg;
  logic        res_valid_reg;
  logic [5:0]  score_reg;
  logic [3:0]  r1x_reg, r1y_reg, r2x_reg, r2y_reg;
  logic        timeout_reg;

  // Writes are only accepted while idle so a running pattern never changes.
  assign mem_we = (state_reg == ST_IDLE) && LD_EN && ({1'b0, LD_ADDR} < NPTS_LIMIT);

  // State, point index and wait counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      wcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      wcnt_reg  <= wcnt_next;
    end
  end

  // Next-state logic; idx_next doubles as the memory read address so data
  // for cycle k is already registered when that cycle begins.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wcnt_next  = wcnt_reg;
    done_take  = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (START) state_next = ST_DRST;
      end
      ST_DRST: begin
        state_next = ST_STREAM;
        idx_next   = '0;
      end
      ST_STREAM: begin
        if (idx_reg == LAST_IDX) begin
          state_next = ST_WAIT;
          wcnt_next  = '0;
        end else begin
          idx_next = idx_reg + 6'd1;
        end
      end
      ST_WAIT: begin
        if (DONE) begin
          done_take  = 1'b1;
          state_next = ST_SCORE;
          idx_next   = '0;
        end else if (wcnt_reg == TMO_CYC - 20'd1) begin
          tmo_hit    = 1'b1;
          state_next = ST_REPORT;
        end else begin
          wcnt_next = wcnt_reg + 20'd1;
        end
      end
      ST_SCORE: begin
        if (idx_reg == LAST_IDX) begin
          state_next = ST_REPORT;
        end else begin
          idx_next = idx_reg + 6'd1;
        end
      end
      ST_REPORT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Memory write port plus registered read for the scoring pass.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[LD_ADDR] <= {LD_X, LD_Y};
    pt_reg <= mem[idx_next];
  end

  // Streamed coordinates come straight from a flop; zero outside STREAM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      xy_reg <= '0;
    end else if (state_next == ST_STREAM) begin
      xy_reg <= mem[idx_next];
    end else begin
      xy_reg <= '0;
    end
  end

  // Coverage test of the current point against both captured centers.
  logic [3:0] cen_x [2];
  logic [3:0] cen_y [2];
  logic [1:0] hit;
  logic [3:0] pt_x, pt_y;

  assign pt_x     = pt_reg[7:4];
  assign pt_y     = pt_reg[3:0];
  assign cen_x[0] = r1x_reg;
  assign cen_y[0] = r1y_reg;
  assign cen_x[1] = r2x_reg;
  assign cen_y[1] = r2y_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cov
      logic [3:0] dx, dy;
      logic [7:0] sqx, sqy;
      logic [8:0] dist2;
      assign dx      = (pt_x >= cen_x[gi]) ? pt_x - cen_x[gi] : cen_x[gi] - pt_x;
      assign dy      = (pt_y >= cen_y[gi]) ? pt_y - cen_y[gi] : cen_y[gi] - pt_y;
      assign sqx     = {4'd0, dx} * {4'd0, dx};
      assign sqy     = {4'd0, dy} * {4'd0, dy};
      assign dist2   = {1'b0, sqx} + {1'b0, sqy};
      assign hit[gi] = (dist2 <= 9'd16);
    end
  endgenerate

  // Result registers: capture on DONE, zero on timeout, accumulate in SCORE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dut_rst_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      score_reg     <= '0;
      r1x_reg       <= '0;
      r1y_reg       <= '0;
      r2x_reg       <= '0;
      r2y_reg       <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      dut_rst_reg   <= (state_next == ST_DRST);
      res_valid_reg <= (state_next == ST_REPORT);
      if (done_take) begin
        r1x_reg     <= C1X;
        r1y_reg     <= C1Y;
        r2x_reg     <= C2X;
        r2y_reg     <= C2Y;
        timeout_reg <= 1'b0;
        score_reg   <= '0;
      end else if (tmo_hit) begin
        timeout_reg <= 1'b1;
        score_reg   <= '0;
      end else if ((state_reg == ST_SCORE) && (|hit)) begin
        score_reg <= score_reg + 6'd1;
      end
    end
  end

  assign DUT_RST   = dut_rst_reg;
  assign X         = xy_reg[7:4];
  assign Y         = xy_reg[3:0];
  assign BUSY      = (state_reg != ST_IDLE);
  assign RES_VALID = res_valid_reg;
  assign SCORE     = score_reg;
  assign R1X       = r1x_reg;
  assign R1Y       = r1y_reg;
  assign R2X       = r2x_reg;
  assign R2Y       = r2y_reg;
  assign TIMEOUT   = timeout_reg;

endmodule

// File: tb/tb_laser_host.sv
// Bench for laser_host: directed runs, a timeline model of the expected
// outputs, and a per-cycle compare process against that model.
module tb_laser_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ld_en, start, done, start_t, done_t;
  logic [5:0] ld_addr;
  logic [3:0] ld_x, ld_y, c1x, c1y, c2x, c2y;

  logic       dut_rst, busy, res_valid, timeout;
  logic [3:0] x, y, r1x, r1y, r2x, r2y;
  logic [5:0] score;

  logic       dut_rst_t, busy_t, res_valid_t, timeout_t;
  logic [3:0] x_t, y_t, r1x_t, r1y_t, r2x_t, r2y_t;
  logic [5:0] score_t;

  laser_host dut (
    .CLK(clk), .RST(rst), .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_X(ld_x), .LD_Y(ld_y),
    .START(start), .DUT_RST(dut_rst), .X(x), .Y(y), .DONE(done),
    .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .BUSY(busy), .RES_VALID(res_valid),
    .SCORE(score), .R1X(r1x), .R1Y(r1y), .R2X(r2x), .R2Y(r2y), .TIMEOUT(timeout)
  );

  // Short-timeout instance for the no-DONE case.
  laser_host #(.NPTS(40), .TMO_CYC(20'd50)) dut_t (
    .CLK(clk), .RST(rst), .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_X(ld_x), .LD_Y(ld_y),
    .START(start_t), .DUT_RST(dut_rst_t), .X(x_t), .Y(y_t), .DONE(done_t),
    .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .BUSY(busy_t), .RES_VALID(res_valid_t),
    .SCORE(score_t), .R1X(r1x_t), .R1Y(r1y_t), .R2X(r2x_t), .R2Y(r2y_t), .TIMEOUT(timeout_t)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // m_t = cycles since the START edge (0 = idle); m_rep = report cycle.
  logic [7:0] m_mem [40];
  int m_t = 0;
  int m_rep = 0;
  bit m_done_hit = 1'b0;
  int exp_score = 0;
  int exp_r [4] = '{0, 0, 0, 0};
  int exp_to = 0;

  function automatic bit near(input int px, input int py, input int cx, input int cy);
    return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= 16;
  endfunction

  function automatic int score_of(input int ax, input int ay, input int bx, input int by);
    int s = 0;
    for (int i = 0; i < 40; i++) begin
      if (near(int'(m_mem[i][7:4]), int'(m_mem[i][3:0]), ax, ay) ||
          near(int'(m_mem[i][7:4]), int'(m_mem[i][3:0]), bx, by)) s++;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      exp_score = 0;
      exp_r = '{0, 0, 0, 0};
      exp_to = 0;
    end else if (m_t == 0) begin
      if (ld_en && ld_addr < 6'd40) m_mem[ld_addr] = {ld_x, ld_y};
      if (start) begin
        m_t = 1;
        m_rep = 1 << 30;
        m_done_hit = 1'b0;
      end
    end else begin
      // WAIT begins at cycle 42 (1 DRST + 40 STREAM cycles after START).
      if (m_t >= 42 && !m_done_hit && done) begin
        m_done_hit = 1'b1;
        m_rep = m_t + 41;
        exp_r = '{int'(c1x), int'(c1y), int'(c2x), int'(c2y)};
        exp_to = 0;
        exp_score = score_of(int'(c1x), int'(c1y), int'(c2x), int'(c2y));
      end
      if (m_t == m_rep) m_t = 0;
      else m_t++;
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      if (m_t == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_dut_rst", dut_rst, 0);
        chk("idle_x", x, 0);
        chk("idle_y", y, 0);
        chk("idle_res_valid", res_valid, 0);
        chk("hold_score", score, exp_score);
        chk("hold_r1x", r1x, exp_r[0]);
        chk("hold_r1y", r1y, exp_r[1]);
        chk("hold_r2x", r2x, exp_r[2]);
        chk("hold_r2y", r2y, exp_r[3]);
        chk("hold_timeout", timeout, exp_to);
      end else begin
        chk("run_busy", busy, 1);
        chk("run_dut_rst", dut_rst, (m_t == 1) ? 1 : 0);
        if (m_t >= 2 && m_t <= 41) begin
          chk("stream_x", x, int'(m_mem[m_t - 2][7:4]));
          chk("stream_y", y, int'(m_mem[m_t - 2][3:0]));
        end else begin
          chk("nostream_x", x, 0);
          chk("nostream_y", y, 0);
        end
        chk("run_res_valid", res_valid, (m_t == m_rep) ? 1 : 0);
        if (m_t == m_rep) begin
          chk("rep_score", score, exp_score);
          chk("rep_r1x", r1x, exp_r[0]);
          chk("rep_r1y", r1y, exp_r[1]);
          chk("rep_r2x", r2x, exp_r[2]);
          chk("rep_r2y", r2y, exp_r[3]);
          chk("rep_timeout", timeout, exp_to);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input int a, input logic [3:0] px, input logic [3:0] py);
    ld_en = 1'b1;
    ld_addr = 6'(a);
    ld_x = px;
    ld_y = py;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // DONE is raised in WAIT cycle w (1-based), i.e. cycle 41+w after START.
  task automatic run_main(input int w, input logic [3:0] ax, input logic [3:0] ay,
                          input logic [3:0] bx, input logic [3:0] by);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40 + w) @(negedge clk);
    done = 1'b1;
    c1x = ax; c1y = ay; c2x = bx; c2y = by;
    @(negedge clk);
    done = 1'b0;
    repeat (42) @(negedge clk);
  endtask

  // Run on the short-timeout instance; w = 0 means DONE never comes.
  task automatic run_t(input int w, input logic [3:0] ax, input logic [3:0] ay,
                       input logic [3:0] bx, input logic [3:0] by);
    int rep;
    rep = (w > 0) ? 82 + w : 92;
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    if (w > 0) begin
      repeat (40 + w) @(negedge clk);
      done_t = 1'b1;
      c1x = ax; c1y = ay; c2x = bx; c2y = by;
      @(negedge clk);
      done_t = 1'b0;
      repeat (rep - 1 - (42 + w)) @(negedge clk);
    end else begin
      repeat (rep - 2) @(negedge clk);
    end
    chk("t_rv_early", res_valid_t, 0);
    chk("t_busy_early", busy_t, 1);
    @(negedge clk);
    chk("t_rv_report", res_valid_t, 1);
    @(negedge clk);
    chk("t_rv_after", res_valid_t, 0);
    chk("t_busy_after", busy_t, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_x = '0; ld_y = '0;
    start = 1'b0; done = 1'b0; start_t = 1'b0; done_t = 1'b0;
    c1x = '0; c1y = '0; c2x = '0; c2y = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);
    chk("reset_score", score, 0);
    chk("reset_timeout", timeout, 0);

    // All points (5,5); engine answers after 100 WAIT cycles.
    for (int i = 0; i < 40; i++) load(i, 4'd5, 4'd5);
    run_main(100, 4'd5, 4'd5, 4'd0, 4'd0);
    chk("lit_score_all55", score, 40);
    chk("lit_model_all55", exp_score, 40);
    chk("lit_r1x", r1x, 5);

    // Timeout instance: good run, timeout run, good run clears the flag.
    run_t(10, 4'd5, 4'd5, 4'd0, 4'd0);
    chk("t_score_good", score_t, 40);
    chk("t_timeout_good", timeout_t, 0);
    run_t(0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("t_timeout_set", timeout_t, 1);
    chk("t_score_forced0", score_t, 0);
    chk("t_r1x_kept", r1x_t, 5);
    run_t(5, 4'd5, 4'd5, 4'd0, 4'd0);
    chk("t_timeout_cleared", timeout_t, 0);
    chk("t_score_again", score_t, 40);

    // Alternating (2,2)/(13,13).
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) load(i, 4'd2, 4'd2);
      else load(i, 4'd13, 4'd13);
    end
    run_main(20, 4'd2, 4'd2, 4'd13, 4'd13);
    chk("lit_score_alt", score, 40);
    run_main(30, 4'd2, 4'd2, 4'd0, 4'd15);
    chk("lit_score_alt_half", score, 20);
    chk("lit_model_alt_half", exp_score, 20);

    // Boundary: (9,5) is at distance^2 16, (8,8) at 18.
    load(0, 4'd9, 4'd5);
    load(1, 4'd8, 4'd8);
    for (int i = 2; i < 40; i++) load(i, 4'd15, 4'd15);
    run_main(7, 4'd5, 4'd5, 4'd0, 4'd0);
    chk("lit_score_boundary", score, 1);

    // RST in STREAM cycle 20, then a full replay from index 0.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_x", x, 0);
    chk("midrst_y", y, 0);
    chk("midrst_score", score, 0);
    run_main(3, 4'd5, 4'd5, 4'd0, 4'd0);
    chk("lit_score_replay", score, 1);

    // START, LD_EN and DONE during STREAM must all be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; done = 1'b1;
    ld_en = 1'b1; ld_addr = 6'd0; ld_x = 4'd0; ld_y = 4'd0;
    @(negedge clk);
    start = 1'b0; done = 1'b0; ld_en = 1'b0;
    repeat (29) @(negedge clk);
    repeat (4) @(negedge clk);
    done = 1'b1;
    c1x = 4'd5; c1y = 4'd5; c2x = 4'd0; c2y = 4'd0;
    @(negedge clk);
    done = 1'b0;
    repeat (42) @(negedge clk);
    chk("lit_score_ignored_ld", score, 1);
    chk("no_second_run", busy, 0);

    // Out-of-range write in IDLE leaves the pattern untouched.
    load(45, 4'd3, 4'd3);
    run_main(2, 4'd5, 4'd5, 4'd0, 4'd0);
    chk("lit_score_addr45", score, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
